pipeline_adder_arbiter: RTL and testbench
=========================================

Name: pipeline_adder_arbiter

Overview:
- Shares one pipelined adder (WIDTH-bit, LATENCY register stages, no stall, no reset) among NREQ requesters.
- Uses valid/ready request and response handshakes.
- Arbitrates round-robin, drives the adder operands, and tracks each in-flight op with a one-hot tag shift pipe matched to the adder latency.
- Steers each result back to a per-requester response register.

Parameters:
- WIDTH, 64, operand/sum width; must match the adder instance.
- NREQ, 4, number of requesters (2..16).
- LATENCY, 2, adder register stages, operand-in to sum-out, in clocks (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request valid per requester.
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero).
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing as req_a.
- req_cin  in  NREQ  carry-in per requester.
- rsp_valid  out  NREQ  result held for requester i.
- rsp_ready  in  NREQ  requester i consumes its result.
- rsp_sum  out  NREQ*WIDTH  per-requester result register, same packing as req_a.
- rsp_cout  out  NREQ  per-requester carry-out.
- add_a  out  WIDTH  adder operand A.
- add_b  out  WIDTH  adder operand B.
- add_cin  out  1  adder carry-in.
- add_sum  in  WIDTH  adder sum, valid LATENCY clocks after issue.
- add_cout  in  1  adder carry-out, same timing as add_sum.
- busy  out  1  |inflight or |rsp_valid.

Behaviour:
- Eligibility: elig[i] = req_valid[i] & ~inflight[i] & ~rsp_valid[i]. Registered terms only; no combinational path from rsp_ready to req_ready.
- Arbitration:
  - Round-robin over elig, starting at rr_ptr.
  - At most one grant per cycle; req_ready = grant (combinational from req_valid and state).
  - rr_ptr <= granted index + 1 (mod NREQ) on a grant; unchanged otherwise.
- Issue: on grant, add_a/add_b/add_cin = granted requester's operands (combinational mux). With no grant they are driven 0.
- Tag pipe:
  - LATENCY stages of {vld, tag[NREQ]}. Stage 0 loads {|grant, grant}.
  - Shifts every clock; never stalls.
- Capture: when the last stage vld = 1, on that edge:
  - rsp_sum/rsp_cout of the tagged requester <= add_sum/add_cout;
  - its rsp_valid <= 1 and inflight <= 0.
- inflight[i] <= 1 on the grant edge.
- Response: rsp_valid[i] clears on an edge with rsp_valid[i] & rsp_ready[i]. rsp_sum holds its value until the next capture.
- Latency: grant at edge T gives capture at edge T+LATENCY; rsp_valid is high from then on.
- Throughput:
  - Per requester, at most one op per LATENCY+2 clocks (the +2 assumes the result is consumed in the capture cycle).
  - In aggregate, one op per clock when enough requesters are active.
- Collisions:
  - A capture never targets an occupied register, because eligibility excludes rsp_valid.
  - A capture and a drain for different requesters in the same cycle are independent.
  - A requester is never re-granted while its op is in flight.
- Reset (asynchronous):
  - Clears tag pipe, inflight, rsp_valid, rsp_sum, rsp_cout, rr_ptr (= 0).
  - Ops in flight mid-operation are discarded. Adder contents are ignored because the tag pipe is empty.
  - Outputs during reset: req_ready = 0, rsp_valid = 0, busy = 0.
- Width rule: sum is mod 2^WIDTH; carry out of the MSB goes to cout.

Optional Feature:
- Macro: PADD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest eligible index wins. rr_ptr is not implemented.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package padd_arb_pkg holds:
  - default WIDTH/NREQ/LATENCY localparams;
  - an index-width helper, clog2(NREQ);
  - a tag-stage struct typedef {vld, tag}.
- One natural sub-module: padd_rr_arbiter (elig in, one-hot grant out, rr_ptr state, honours PADD_ARB_FIXED_PRIO_EN).
- The tag pipe and response registers live in the top.

Test Plan:
- Single op:
  - Stimulus: req0 a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 at edge T.
  - Expected: rsp_valid[0] rises after edge T+2 with sum=0, cout=1; busy high from T until drain.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold req_valid, all rsp_ready=1.
  - Expected: grants go 0,1,2,3,0,...; one grant per cycle; each result equals a+b+cin of its own operands.
- Backpressure:
  - Stimulus: req1 issues a=5, b=7, cin=1; hold rsp_ready[1]=0 for 10 cycles.
  - Expected: rsp_sum=13 stays stable; req_ready[1]=0 throughout while others are still granted; after drain req1 is eligible the next cycle.
- No re-grant in flight:
  - Stimulus: req2 valid continuously.
  - Expected: req_ready[2] pulses no more often than once per 4 clocks.
- Reset mid-flight:
  - Stimulus: assert rst one cycle after issuing on req0 and req3.
  - Expected: all rsp_valid=0, busy=0 immediately; no response appears after rst is released.
- Fixed-priority build (PADD_ARB_FIXED_PRIO_EN defined):
  - Stimulus: req0 and req3 continuously valid.
  - Expected: req0 is granted whenever eligible; req3 is granted only in cycles where req0 is ineligible.

Source files
------------

// File: rtl/padd_arb_pkg.sv
// Shared defaults, index-width helper and the tag-stage type for the
// shared pipelined adder arbiter.
package padd_arb_pkg;

    localparam int unsigned DEF_WIDTH   = 32'd64;
    localparam int unsigned DEF_NREQ    = 32'd4;
    localparam int unsigned DEF_LATENCY = 32'd2;

    // Upper bound on requesters; the tag field is sized to this and only
    // the low NREQ bits carry meaning.
    localparam int unsigned MAX_NREQ    = 32'd16;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

    // One stage of the in-flight tag pipe.
    typedef struct packed {
        logic                vld;
        logic [MAX_NREQ-1:0] tag;
    } tag_stage_t;

endpackage

// File: rtl/padd_rr_arbiter.sv
// Single-grant arbiter over an eligibility vector.
// Default build: round-robin starting at rr_ptr, pointer advances past the
// winner. With PADD_ARB_FIXED_PRIO_EN defined: lowest eligible index wins
// and no pointer state exists.
module padd_rr_arbiter
    import padd_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] elig,
    output logic [NREQ-1:0] grant
);

    localparam int unsigned IW = idx_w(NREQ);

    logic [NREQ-1:0] grant_s;
    logic            found_s;
    logic            take_s;

`ifdef PADD_ARB_FIXED_PRIO_EN

    logic unused_s;
    assign unused_s = clk ^ rst;

    // Lowest eligible index wins.
    always_comb begin
        grant_s = '0;
        found_s = 1'b0;
        take_s  = 1'b0;
        for (int unsigned k = 32'd0; k < NREQ; k++) begin
            take_s            = ~found_s & elig[IW'(k)];
            grant_s[IW'(k)]   = grant_s[IW'(k)] | take_s;
            found_s           = found_s | take_s;
        end
    end

`else

    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] rr_ptr_d;
    logic [IW-1:0] cand_idx_s;
    int unsigned   cand_s;

    // Scan from rr_ptr upward (wrapping) and grant the first eligible.
    always_comb begin
        grant_s    = '0;
        found_s    = 1'b0;
        take_s     = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        cand_s     = 32'd0;
        cand_idx_s = '0;
        for (int unsigned k = 32'd0; k < NREQ; k++) begin
            cand_s              = (32'(rr_ptr_q) + k) % NREQ;
            cand_idx_s          = IW'(cand_s);
            take_s              = ~found_s & elig[cand_idx_s];
            grant_s[cand_idx_s] = grant_s[cand_idx_s] | take_s;
            rr_ptr_d            = take_s ? IW'((cand_s + 32'd1) % NREQ) : rr_ptr_d;
            found_s             = found_s | take_s;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`endif

    assign grant = grant_s;

endmodule

// File: rtl/pipeline_adder_arbiter.sv
// Shares one external pipelined adder among NREQ requesters. A one-hot tag
// pipe of LATENCY stages follows each issued op so the sum emerging from
// the adder is steered into the owning requester's response register.
// Optional build macro: PADD_ARB_FIXED_PRIO_EN (fixed priority arbitration,
// handled inside padd_rr_arbiter).
module pipeline_adder_arbiter
    import padd_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned NREQ    = DEF_NREQ,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [NREQ*WIDTH-1:0] rsp_sum,
    output logic [NREQ-1:0]       rsp_cout,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic                  busy
);

    logic [NREQ-1:0]       elig_s;
    logic [NREQ-1:0]       grant_s;
    logic [NREQ-1:0]       cap_s;
    logic [NREQ-1:0]       inflight_q, inflight_d;
    logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [NREQ*WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic [NREQ-1:0]       rsp_cout_q, rsp_cout_d;
    logic [WIDTH-1:0]      add_a_s, add_b_s;
    logic                  add_cin_s;
    tag_stage_t            pipe_q [LATENCY];
    tag_stage_t            pipe_d [LATENCY];
    tag_stage_t            last_s;
    logic                  unused_tag_s;

    // Only registered state gates eligibility; reset forces no grant.
    assign elig_s = req_valid & ~inflight_q & ~rsp_valid_q & {NREQ{~rst}};

    padd_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .elig  (elig_s),
        .grant (grant_s)
    );

    // One-hot operand mux onto the adder; all zero when nothing is granted.
    always_comb begin
        add_a_s   = '0;
        add_b_s   = '0;
        add_cin_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            add_a_s   = add_a_s | (req_a[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
            add_b_s   = add_b_s | (req_b[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
            add_cin_s = add_cin_s | (req_cin[i] & grant_s[i]);
        end
    end

    // Tag pipe next state: stage 0 takes the grant, the rest shift.
    always_comb begin
        pipe_d[0].vld = |grant_s;
        pipe_d[0].tag = MAX_NREQ'(grant_s);
        for (int s = 1; s < LATENCY; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
    end

    assign last_s       = pipe_q[LATENCY-1];
    assign unused_tag_s = ^last_s.tag;

    // Requester whose result is on the adder output this cycle.
    always_comb begin
        cap_s = last_s.vld ? last_s.tag[NREQ-1:0] : '0;
    end

    // Response and in-flight bookkeeping; capture never targets a held slot.
    always_comb begin
        inflight_d  = (inflight_q | grant_s) & ~cap_s;
        rsp_valid_d = (rsp_valid_q & ~rsp_ready) | cap_s;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        for (int i = 0; i < NREQ; i++) begin
            rsp_sum_d[i*WIDTH +: WIDTH] = cap_s[i] ? add_sum : rsp_sum_q[i*WIDTH +: WIDTH];
            rsp_cout_d[i]               = cap_s[i] ? add_cout : rsp_cout_q[i];
        end
    end

    // State registers; reset empties the tag pipe so stale adder data is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                pipe_q[s] <= '0;
            end
            inflight_q  <= '0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= '0;
        end else begin
            for (int s = 0; s < LATENCY; s++) begin
                pipe_q[s] <= pipe_d[s];
            end
            inflight_q  <= inflight_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign req_ready = grant_s;
    assign add_a     = add_a_s;
    assign add_b     = add_b_s;
    assign add_cin   = add_cin_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = (|inflight_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_pipeline_adder_arbiter.sv
// Bench for pipeline_adder_arbiter: models the external adder, keeps a
// per-requester behavioural model (idle / in flight / result held) and
// compares every cycle, plus directed scenarios with literal expectations.
module tb_pipeline_adder_arbiter;

    localparam int N = 4;
    localparam int W = 64;
    localparam int L = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, req_cin;
    logic [N*W-1:0] req_a, req_b, rsp_sum;
    logic [N-1:0]   rsp_valid, rsp_ready, rsp_cout;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic           add_cin, add_cout, busy;

    pipeline_adder_arbiter #(.WIDTH(W), .NREQ(N), .LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External adder: L register stages, no reset, no stall.
    logic [W:0] apipe [L];
    always @(posedge clk) begin
        apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
        for (int k = 1; k < L; k++) apipe[k] <= apipe[k-1];
    end
    assign add_sum  = apipe[L-1][W-1:0];
    assign add_cout = apipe[L-1][W];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 idle, 1 op in flight, 2 result held.
    int         mst [N], n_mst [N];
    int         rem [N], n_rem [N];
    logic [W:0] fres [N], n_fres [N];
    logic [W:0] hres [N], n_hres [N];
    int         rr, n_rr;

    // Model state update on each edge; asynchronous reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mst[i] = 0; rem[i] = 0; fres[i] = '0; hres[i] = '0;
            end
            rr = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                mst[i] = n_mst[i]; rem[i] = n_rem[i];
                fres[i] = n_fres[i]; hres[i] = n_hres[i];
            end
            rr = n_rr;
        end
    end

    // Compare process: expected outputs from model state and current inputs.
    always @(negedge clk) begin : model_cmp
        int g, idx;
        logic [N-1:0] e_ready, e_valid;
        logic [W-1:0] e_a, e_b;
        logic e_cin, e_busy;
        g = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
`ifdef PADD_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (rr + k) % N;
`endif
                if (g < 0 && req_valid[idx] && mst[idx] == 0) g = idx;
            end
        end
        e_ready = '0; e_a = '0; e_b = '0; e_cin = 1'b0;
        if (g >= 0) begin
            e_ready[g] = 1'b1;
            e_a = req_a[g*W +: W];
            e_b = req_b[g*W +: W];
            e_cin = req_cin[g];
        end
        e_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            e_valid[i] = (mst[i] == 2);
            if (mst[i] != 0) e_busy = 1'b1;
        end
        chk("m_req_ready", W'(req_ready), W'(e_ready));
        chk("m_add_a", add_a, e_a);
        chk("m_add_b", add_b, e_b);
        chk("m_add_cin", W'(add_cin), W'(e_cin));
        chk("m_rsp_valid", W'(rsp_valid), W'(e_valid));
        chk("m_busy", W'(busy), W'(e_busy));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("m_rsp_sum%0d", i), rsp_sum[i*W +: W], hres[i][W-1:0]);
            chk($sformatf("m_rsp_cout%0d", i), W'(rsp_cout[i]), W'(hres[i][W]));
        end
        for (int i = 0; i < N; i++) begin
            n_mst[i] = mst[i]; n_rem[i] = rem[i];
            n_fres[i] = fres[i]; n_hres[i] = hres[i];
            if (mst[i] == 1) begin
                if (rem[i] == 1) begin
                    n_mst[i] = 2;
                    n_hres[i] = fres[i];
                end else begin
                    n_rem[i] = rem[i] - 1;
                end
            end else if (mst[i] == 2 && rsp_ready[i]) begin
                n_mst[i] = 0;
            end
        end
        n_rr = rr;
        if (g >= 0) begin
            n_mst[g] = 1;
            n_rem[g] = L;
            n_fres[g] = {1'b0, e_a} + {1'b0, e_b} + (W+1)'(e_cin);
            n_rr = (g + 1) % N;
        end
    end

    task automatic nxt();
        @(posedge clk); #2;
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i] = c;
    endtask

    function automatic logic [W-1:0] rnd64();
        logic [W-1:0] v;
        v = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) v = '1;
        return v;
    endfunction

    int others, last, pulses;

    initial begin
        rst = 1'b1;
        req_valid = '1; rsp_ready = '0;
        req_a = '0; req_b = '0; req_cin = '0;
        repeat (3) @(posedge clk);
        #2;
        smp();
        chk("rst_req_ready", W'(req_ready), 64'd0);
        chk("rst_rsp_valid", W'(rsp_valid), 64'd0);
        chk("rst_busy", W'(busy), 64'd0);
        nxt();
        rst = 1'b0;

        // Single op: all-ones + 1 wraps to zero with carry out.
        set_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        req_valid = 4'b0001;
        smp();
        chk("single_grant", W'(req_ready), 64'd1);
        nxt();
        req_valid = 4'b0000;
        smp();
        chk("single_busy_T", W'(busy), 64'd1);
        chk("single_valid_T", W'(rsp_valid[0]), 64'd0);
        nxt();
        smp();
        chk("single_valid_T1", W'(rsp_valid[0]), 64'd0);
        nxt();
        smp();
        chk("single_valid_T2", W'(rsp_valid[0]), 64'd1);
        chk("single_sum", rsp_sum[0 +: W], 64'd0);
        chk("single_cout", W'(rsp_cout[0]), 64'd1);
        nxt();
        rsp_ready = 4'b1111;
        nxt();
        smp();
        chk("single_drained_busy", W'(busy), 64'd0);

        // Round-robin fairness from a fresh pointer.
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, rnd64(), rnd64(), 1'($urandom));
        req_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            smp();
            chk($sformatf("rr_grant%0d", k), W'(req_ready), W'(4'b0001 << (k % 4)));
            nxt();
        end
        req_valid = '0;
        repeat (4) nxt();

        // Backpressure on requester 1.
        set_op(1, 64'd5, 64'd7, 1'b1);
        req_valid = 4'b0010;
        rsp_ready = 4'b1101;
        smp();
        chk("bp_grant", W'(req_ready), 64'd2);
        nxt();
        req_valid = 4'b1111;
        others = 0;
        for (int k = 0; k < 12; k++) begin
            smp();
            chk("bp_ready1", W'(req_ready[1]), 64'd0);
            if ((req_ready & 4'b1101) != 4'b0000) others++;
            if (k >= 2) begin
                chk("bp_valid1", W'(rsp_valid[1]), 64'd1);
                chk("bp_sum1", rsp_sum[1*W +: W], 64'd13);
            end
            nxt();
        end
        chk("bp_others_granted", W'(others > 0), 64'd1);
        rsp_ready = 4'b1111;
        req_valid = 4'b0000;
        nxt();
        req_valid = 4'b0010;
        smp();
        chk("bp_regrant", W'(req_ready), 64'd2);
        chk("bp_sum_hold", rsp_sum[1*W +: W], 64'd13);
        nxt();
        req_valid = '0;
        repeat (4) nxt();

        // Continuous requester 2: one grant per L+2 clocks.
        set_op(2, rnd64(), rnd64(), 1'b1);
        req_valid = 4'b0100;
        last = -1; pulses = 0;
        for (int k = 0; k < 20; k++) begin
            smp();
            if (req_ready[2]) begin
                if (last >= 0) chk("regrant_gap", W'(k - last), W'(L + 2));
                last = k;
                pulses++;
            end
            nxt();
        end
        chk("regrant_pulses", W'(pulses), 64'd5);
        req_valid = '0;
        repeat (4) nxt();

        // Reset with ops from requesters 0 and 3 in flight.
        set_op(0, rnd64(), rnd64(), 1'b0);
        set_op(3, rnd64(), rnd64(), 1'b1);
        req_valid = 4'b1001;
        smp();
        nxt();
        smp();
        chk("mid_busy", W'(busy), 64'd1);
        nxt();
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", W'(rsp_valid), 64'd0);
        chk("mid_rst_busy", W'(busy), 64'd0);
        chk("mid_rst_ready", W'(req_ready), 64'd0);
        nxt();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            smp();
            chk("post_rst_valid", W'(rsp_valid), 64'd0);
            chk("post_rst_busy", W'(busy), 64'd0);
            nxt();
        end

        // Requesters 0 and 3 continuously valid from reset pointer.
        set_op(0, rnd64(), rnd64(), 1'b1);
        set_op(3, rnd64(), rnd64(), 1'b0);
        req_valid = 4'b1001;
        for (int k = 0; k < 12; k++) begin
            smp();
            chk($sformatf("prio_grant%0d", k), W'(req_ready),
                (k % 4 == 0) ? 64'd1 : ((k % 4 == 1) ? 64'd8 : 64'd0));
            nxt();
        end

        // Randomized traffic with occasional reset pulses.
        for (int c = 0; c < 1500; c++) begin
            req_valid = 4'($urandom);
            rsp_ready = 4'($urandom) | 4'($urandom);
            for (int i = 0; i < N; i++) set_op(i, rnd64(), rnd64(), 1'($urandom));
            rst = ($urandom_range(0, 199) == 0);
            nxt();
        end
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        repeat (6) nxt();
        smp();
        chk("final_busy", W'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
